ysyx_23060077_axi_arbiter: RTL and testbench

YSYX_23060077_AXI_ARBITER -- requirements
Module: ysyx_23060077_axi_arbiter

---
 rtl/ysyx_23060077_axi_arbiter_pkg.sv | 31 +++
 rtl/ysyx_23060077_rr_arb2.sv | 24 ++
 rtl/ysyx_23060077_axi_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_23060077_axi_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060077_axi_arbiter_pkg.sv
// Shared definitions for the AXI arbiter: bus field widths, arbiter state
// encoding, requester port indices and the latched request descriptor.
package ysyx_23060077_axi_arbiter_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_SIZE_W = 3;
  localparam int AXI_LEN_W  = 8;

  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFU_RD = 2'd1,
    ARB_LSU_RD = 2'd2,
    ARB_LSU_WR = 2'd3
  } arb_state_e;

  // Bit positions in the round-robin request/grant vectors; the last-grant
  // register stores one of these indices.
  localparam int PORT_IFU = 0;
  localparam int PORT_LSU = 1;

  // Request descriptor captured at grant time and held for the whole burst.
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_SIZE_W-1:0] size;
    logic [AXI_LEN_W-1:0]  len;
  } axi_req_t;

endpackage

// File: rtl/ysyx_23060077_rr_arb2.sv
// Two-way round-robin picker.
// Ports:
//   req_i        - request vector, bit 0 = IFU read, bit 1 = LSU read
//   last_grant_i - index of the port granted last (0 = IFU, 1 = LSU)
//   grant_o      - one-hot grant, all zero when nothing is requested
module ysyx_23060077_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    // NOTE: default first so every path assigns grant_o; no latch is inferred.
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // On a tie the port that was not served last wins.
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060077_axi_arbiter.sv
// Arbitrates the IFU read, LSU read and LSU write ports onto a single
// downstream AXI master bridge, one transaction at a time.
// Ports:
//   aclk, areset_n     - clock, synchronous active-low reset
//   ifu_r_*            - IFU read request in, routed beat ready/data/last out
//   lsu_r_*            - LSU read request in, routed beat ready/data/last out
//   lsu_w_*            - LSU write request/data in, routed ready/last out
//   cpu_r_*, cpu_w_*   - downstream request pulse + latched addr/size/len out,
//                        beat handshakes and read data in
module ysyx_23060077_axi_arbiter
  import ysyx_23060077_axi_arbiter_pkg::*;
(
  input  logic                  aclk,
  input  logic                  areset_n,
  // IFU read port
  input  logic                  ifu_r_valid_i,
  input  logic [AXI_ADDR_W-1:0] ifu_r_addr_i,
  input  logic [AXI_SIZE_W-1:0] ifu_r_size_i,
  input  logic [AXI_LEN_W-1:0]  ifu_r_len_i,
  output logic                  ifu_r_ready_o,
  output logic [AXI_DATA_W-1:0] ifu_r_data_o,
  output logic                  ifu_r_last_o,
  // LSU read port
  input  logic                  lsu_r_valid_i,
  input  logic [AXI_ADDR_W-1:0] lsu_r_addr_i,
  input  logic [AXI_SIZE_W-1:0] lsu_r_size_i,
  input  logic [AXI_LEN_W-1:0]  lsu_r_len_i,
  output logic                  lsu_r_ready_o,
  output logic [AXI_DATA_W-1:0] lsu_r_data_o,
  output logic                  lsu_r_last_o,
  // LSU write port
  input  logic                  lsu_w_valid_i,
  input  logic [AXI_ADDR_W-1:0] lsu_w_addr_i,
  input  logic [AXI_DATA_W-1:0] lsu_w_data_i,
  input  logic [AXI_SIZE_W-1:0] lsu_w_size_i,
  input  logic [AXI_LEN_W-1:0]  lsu_w_len_i,
  output logic                  lsu_w_ready_o,
  output logic                  lsu_w_last_o,
  // Downstream bridge
  output logic                  cpu_r_valid_o,
  output logic [AXI_ADDR_W-1:0] cpu_r_addr_o,
  output logic [AXI_SIZE_W-1:0] cpu_r_size_o,
  output logic [AXI_LEN_W-1:0]  cpu_r_len_o,
  input  logic                  cpu_r_ready_i,
  input  logic                  cpu_r_last_i,
  input  logic [AXI_DATA_W-1:0] cpu_r_data_i,
  output logic                  cpu_w_valid_o,
  output logic [AXI_ADDR_W-1:0] cpu_w_addr_o,
  output logic [AXI_SIZE_W-1:0] cpu_w_size_o,
  output logic [AXI_LEN_W-1:0]  cpu_w_len_o,
  output logic [AXI_DATA_W-1:0] cpu_w_data_o,
  input  logic                  cpu_w_ready_i,
  input  logic                  cpu_w_last_i
);

  arb_state_e state_q;
  logic       last_grant_q;
  logic       r_valid_q;
  logic       w_valid_q;
  axi_req_t   rd_req_q, rd_req_d;
  axi_req_t   wr_req_q, wr_req_d;
  logic [1:0] rr_grant;

  ysyx_23060077_rr_arb2 u_rr_arb2 (
    .req_i        ({lsu_r_valid_i, ifu_r_valid_i}),
    .last_grant_i (last_grant_q),
    .grant_o      (rr_grant)
  );

  // Descriptor that would be latched if a grant happens this cycle.
  always_comb begin
    if (rr_grant[PORT_LSU]) begin
      rd_req_d.addr = lsu_r_addr_i;
      rd_req_d.size = lsu_r_size_i;
      rd_req_d.len  = lsu_r_len_i;
    end else begin
      rd_req_d.addr = ifu_r_addr_i;
      rd_req_d.size = ifu_r_size_i;
      rd_req_d.len  = ifu_r_len_i;
    end
    wr_req_d.addr = lsu_w_addr_i;
    wr_req_d.size = lsu_w_size_i;
    wr_req_d.len  = lsu_w_len_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b0;  // IFU counts as last served, so LSU wins the first tie
      r_valid_q    <= 1'b0;
      w_valid_q    <= 1'b0;
      rd_req_q     <= '0;
      wr_req_q     <= '0;
    end else begin
      // Request valids are single-cycle pulses on entry to a grant state.
      r_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (lsu_w_valid_i) begin
            state_q   <= ARB_LSU_WR;
            wr_req_q  <= wr_req_d;
            w_valid_q <= 1'b1;
          end else if (rr_grant[PORT_LSU]) begin
            state_q      <= ARB_LSU_RD;
            rd_req_q     <= rd_req_d;
            r_valid_q    <= 1'b1;
            last_grant_q <= 1'b1;
          end else if (rr_grant[PORT_IFU]) begin
            state_q      <= ARB_IFU_RD;
            rd_req_q     <= rd_req_d;
            r_valid_q    <= 1'b1;
            last_grant_q <= 1'b0;
          end
        end
        ARB_IFU_RD, ARB_LSU_RD: begin
          if (cpu_r_ready_i && cpu_r_last_i) state_q <= ARB_IDLE;
        end
        ARB_LSU_WR: begin
          if (cpu_w_last_i) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Output routing. The reset is synchronous, so the pass-through paths are
  // also gated by areset_n to keep every output quiet for the whole reset
  // cycle rather than only after the next edge.
  always_comb begin
    ifu_r_ready_o = 1'b0;
    ifu_r_last_o  = 1'b0;
    ifu_r_data_o  = '0;
    lsu_r_ready_o = 1'b0;
    lsu_r_last_o  = 1'b0;
    lsu_r_data_o  = '0;
    lsu_w_ready_o = 1'b0;
    lsu_w_last_o  = 1'b0;
    cpu_r_valid_o = 1'b0;
    cpu_r_addr_o  = '0;
    cpu_r_size_o  = '0;
    cpu_r_len_o   = '0;
    cpu_w_valid_o = 1'b0;
    cpu_w_addr_o  = '0;
    cpu_w_size_o  = '0;
    cpu_w_len_o   = '0;
    cpu_w_data_o  = '0;
    if (areset_n) begin
      ifu_r_data_o  = cpu_r_data_i;
      lsu_r_data_o  = cpu_r_data_i;
      cpu_r_valid_o = r_valid_q;
      cpu_r_addr_o  = rd_req_q.addr;
      cpu_r_size_o  = rd_req_q.size;
      cpu_r_len_o   = rd_req_q.len;
      cpu_w_valid_o = w_valid_q;
      cpu_w_addr_o  = wr_req_q.addr;
      cpu_w_size_o  = wr_req_q.size;
      cpu_w_len_o   = wr_req_q.len;
      case (state_q)
        ARB_IFU_RD: begin
          ifu_r_ready_o = cpu_r_ready_i;
          ifu_r_last_o  = cpu_r_last_i;
        end
        ARB_LSU_RD: begin
          lsu_r_ready_o = cpu_r_ready_i;
          lsu_r_last_o  = cpu_r_last_i;
        end
        ARB_LSU_WR: begin
          cpu_w_data_o  = lsu_w_data_i;
          lsu_w_ready_o = cpu_w_ready_i;
          lsu_w_last_o  = cpu_w_last_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_axi_arbiter.sv
// Directed bench for ysyx_23060077_axi_arbiter: expected grants are queued
// when requests are raised and compared when the request pulse appears.
module tb_ysyx_23060077_axi_arbiter;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        ifu_r_valid_i = 1'b0;
  logic [31:0] ifu_r_addr_i = '0;
  logic [2:0]  ifu_r_size_i = '0;
  logic [7:0]  ifu_r_len_i = '0;
  logic        ifu_r_ready_o;
  logic [63:0] ifu_r_data_o;
  logic        ifu_r_last_o;
  logic        lsu_r_valid_i = 1'b0;
  logic [31:0] lsu_r_addr_i = '0;
  logic [2:0]  lsu_r_size_i = '0;
  logic [7:0]  lsu_r_len_i = '0;
  logic        lsu_r_ready_o;
  logic [63:0] lsu_r_data_o;
  logic        lsu_r_last_o;
  logic        lsu_w_valid_i = 1'b0;
  logic [31:0] lsu_w_addr_i = '0;
  logic [63:0] lsu_w_data_i = '0;
  logic [2:0]  lsu_w_size_i = '0;
  logic [7:0]  lsu_w_len_i = '0;
  logic        lsu_w_ready_o;
  logic        lsu_w_last_o;
  logic        cpu_r_valid_o;
  logic [31:0] cpu_r_addr_o;
  logic [2:0]  cpu_r_size_o;
  logic [7:0]  cpu_r_len_o;
  logic        cpu_r_ready_i = 1'b0;
  logic        cpu_r_last_i = 1'b0;
  logic [63:0] cpu_r_data_i = '0;
  logic        cpu_w_valid_o;
  logic [31:0] cpu_w_addr_o;
  logic [2:0]  cpu_w_size_o;
  logic [7:0]  cpu_w_len_o;
  logic [63:0] cpu_w_data_o;
  logic        cpu_w_ready_i = 1'b0;
  logic        cpu_w_last_i = 1'b0;

  ysyx_23060077_axi_arbiter dut (
    .aclk(aclk), .areset_n(areset_n),
    .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i),
    .ifu_r_size_i(ifu_r_size_i), .ifu_r_len_i(ifu_r_len_i),
    .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o), .ifu_r_last_o(ifu_r_last_o),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i),
    .lsu_r_size_i(lsu_r_size_i), .lsu_r_len_i(lsu_r_len_i),
    .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o), .lsu_r_last_o(lsu_r_last_o),
    .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i), .lsu_w_data_i(lsu_w_data_i),
    .lsu_w_size_i(lsu_w_size_i), .lsu_w_len_i(lsu_w_len_i),
    .lsu_w_ready_o(lsu_w_ready_o), .lsu_w_last_o(lsu_w_last_o),
    .cpu_r_valid_o(cpu_r_valid_o), .cpu_r_addr_o(cpu_r_addr_o),
    .cpu_r_size_o(cpu_r_size_o), .cpu_r_len_o(cpu_r_len_o),
    .cpu_r_ready_i(cpu_r_ready_i), .cpu_r_last_i(cpu_r_last_i), .cpu_r_data_i(cpu_r_data_i),
    .cpu_w_valid_o(cpu_w_valid_o), .cpu_w_addr_o(cpu_w_addr_o),
    .cpu_w_size_o(cpu_w_size_o), .cpu_w_len_o(cpu_w_len_o), .cpu_w_data_o(cpu_w_data_o),
    .cpu_w_ready_i(cpu_w_ready_i), .cpu_w_last_i(cpu_w_last_i)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  bit   pulse_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [7:0] len);
    exp_t e;
    e.wr = wr; e.addr = addr; e.size = size; e.len = len;
    sb.push_back(e);
  endtask

  // Any request pulse must match the oldest queued expectation.
  task automatic observe();
    exp_t e;
    if (cpu_r_valid_o === 1'b1 || cpu_w_valid_o === 1'b1) begin
      pulses++;
      pulse_seen = 1'b1;
      check("sb_pending", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("grant_kind", 64'(cpu_w_valid_o), 64'(e.wr));
        check("grant_single", 64'(cpu_r_valid_o & cpu_w_valid_o), 64'(0));
        if (e.wr) begin
          check("grant_w_addr", 64'(cpu_w_addr_o), 64'(e.addr));
          check("grant_w_size", 64'(cpu_w_size_o), 64'(e.size));
          check("grant_w_len",  64'(cpu_w_len_o),  64'(e.len));
        end else begin
          check("grant_r_addr", 64'(cpu_r_addr_o), 64'(e.addr));
          check("grant_r_size", 64'(cpu_r_size_o), 64'(e.size));
          check("grant_r_len",  64'(cpu_r_len_o),  64'(e.len));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
    observe();
  endtask

  task automatic await_grant(input string tag, output int n);
    n = 0;
    pulse_seen = 1'b0;
    while (!pulse_seen && n < 20) begin
      step();
      n++;
    end
    check({tag, "_granted"}, 64'(pulse_seen), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    logic any;
    any = |{ifu_r_ready_o, ifu_r_data_o, ifu_r_last_o,
            lsu_r_ready_o, lsu_r_data_o, lsu_r_last_o,
            lsu_w_ready_o, lsu_w_last_o,
            cpu_r_valid_o, cpu_r_addr_o, cpu_r_size_o, cpu_r_len_o,
            cpu_w_valid_o, cpu_w_addr_o, cpu_w_size_o, cpu_w_len_o, cpu_w_data_o};
    check(tag, 64'(any), 64'(0));
  endtask

  // Acts as the downstream bridge for a read burst; the requester drops
  // valid together with the final beat.
  task automatic serve_read(input bit lsu, input int beats, input logic [63:0] base);
    logic lst;
    for (int b = 0; b < beats; b++) begin
      lst = (b == beats - 1);
      cpu_r_ready_i = 1'b1;
      cpu_r_last_i  = lst;
      cpu_r_data_i  = base + 64'(b);
      if (lst) begin
        if (lsu) lsu_r_valid_i = 1'b0;
        else     ifu_r_valid_i = 1'b0;
      end
      #1;
      check("rd_ready", 64'(lsu ? lsu_r_ready_o : ifu_r_ready_o), 64'(1));
      check("rd_last",  64'(lsu ? lsu_r_last_o  : ifu_r_last_o),  64'(lst));
      check("rd_data",  lsu ? lsu_r_data_o : ifu_r_data_o, base + 64'(b));
      check("rd_other_quiet",
            64'(lsu ? (ifu_r_ready_o | ifu_r_last_o) : (lsu_r_ready_o | lsu_r_last_o)), 64'(0));
      step();
    end
    cpu_r_ready_i = 1'b0;
    cpu_r_last_i  = 1'b0;
  endtask

  task automatic serve_write(input int beats, input logic [63:0] base, input logic [31:0] waddr);
    for (int b = 0; b < beats; b++) begin
      lsu_w_data_i  = base + 64'(b);
      cpu_w_ready_i = 1'b1;
      if (b == 1) begin
        lsu_w_addr_i  = 32'hFFFF_0000;
        cpu_r_ready_i = 1'b1;
        cpu_r_last_i  = 1'b1;
      end
      #1;
      check("wr_data", cpu_w_data_o, base + 64'(b));
      check("wr_ready", 64'(lsu_w_ready_o), 64'(1));
      check("wr_last_early", 64'(lsu_w_last_o), 64'(0));
      check("wr_addr_hold", 64'(cpu_w_addr_o), 64'(waddr));
      if (b == 1)
        check("wr_ignores_rd", 64'(ifu_r_ready_o | lsu_r_ready_o | ifu_r_last_o | lsu_r_last_o), 64'(0));
      step();
      cpu_r_ready_i = 1'b0;
      cpu_r_last_i  = 1'b0;
    end
    cpu_w_ready_i = 1'b0;
    #1;
    check("wr_ready_gap", 64'(lsu_w_ready_o), 64'(0));
    step();
    cpu_w_last_i  = 1'b1;
    lsu_w_valid_i = 1'b0;
    #1;
    check("wr_resp_last", 64'(lsu_w_last_o), 64'(1));
    step();
    cpu_w_last_i = 1'b0;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    step();
    step();
    areset_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;

    // Reset: downstream activity must not leak through.
    cpu_r_data_i  = 64'hDEAD_BEEF;
    cpu_r_ready_i = 1'b1;
    cpu_r_last_i  = 1'b1;
    lsu_w_data_i  = 64'h55;
    step();
    step();
    check_all_zero("reset_outputs");
    cpu_r_data_i  = '0;
    cpu_r_ready_i = 1'b0;
    cpu_r_last_i  = 1'b0;
    lsu_w_data_i  = '0;
    areset_n = 1'b1;
    step();
    check_all_zero("idle_outputs");

    // Handshakes are ignored in IDLE.
    cpu_w_last_i  = 1'b1;
    cpu_r_ready_i = 1'b1;
    cpu_r_last_i  = 1'b1;
    #1;
    check("idle_ignore_handshakes",
          64'(lsu_w_last_o | lsu_w_ready_o | ifu_r_ready_o | lsu_r_ready_o | ifu_r_last_o | lsu_r_last_o), 64'(0));
    step();
    cpu_w_last_i  = 1'b0;
    cpu_r_ready_i = 1'b0;
    cpu_r_last_i  = 1'b0;

    // Single IFU read, len 0, data returned two cycles after the pulse.
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0000; ifu_r_size_i = 3'd3; ifu_r_len_i = 8'd0;
    push_exp(1'b0, 32'h8000_0000, 3'd3, 8'd0);
    await_grant("ifu_single", n);
    check("ifu_single_latency", 64'(n), 64'(1));
    ifu_r_addr_i = 32'h1111_2222;
    step();
    check("r_valid_pulse_width", 64'(cpu_r_valid_o), 64'(0));
    check("rd_addr_hold", 64'(cpu_r_addr_o), 64'h8000_0000);
    check("ifu_ready_idle_beat", 64'(ifu_r_ready_o), 64'(0));
    step();
    serve_read(1'b0, 1, 64'h1234);

    // Read ties after reset: LSU first, then IFU; round-robin afterwards.
    do_reset();
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0100; ifu_r_size_i = 3'd2; ifu_r_len_i = 8'd1;
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_1000; lsu_r_size_i = 3'd3; lsu_r_len_i = 8'd0;
    push_exp(1'b0, 32'h8000_1000, 3'd3, 8'd0);
    push_exp(1'b0, 32'h8000_0100, 3'd2, 8'd1);
    await_grant("tie1_lsu", n);
    serve_read(1'b1, 1, 64'h100);
    await_grant("tie1_ifu", n);
    check("b2b_idle_cycle", 64'(n), 64'(1));
    serve_read(1'b0, 2, 64'h200);

    ifu_r_valid_i = 1'b1;
    lsu_r_valid_i = 1'b1;
    push_exp(1'b0, 32'h8000_1000, 3'd3, 8'd0);
    push_exp(1'b0, 32'h8000_0100, 3'd2, 8'd1);
    await_grant("tie2_lsu", n);
    serve_read(1'b1, 1, 64'h300);
    await_grant("tie2_ifu", n);
    serve_read(1'b0, 2, 64'h400);

    lsu_r_valid_i = 1'b1;
    push_exp(1'b0, 32'h8000_1000, 3'd3, 8'd0);
    await_grant("lsu_alone", n);
    serve_read(1'b1, 1, 64'h500);

    ifu_r_valid_i = 1'b1;
    lsu_r_valid_i = 1'b1;
    push_exp(1'b0, 32'h8000_0100, 3'd2, 8'd1);
    push_exp(1'b0, 32'h8000_1000, 3'd3, 8'd0);
    await_grant("tie3_ifu", n);
    serve_read(1'b0, 2, 64'h600);
    await_grant("tie3_lsu", n);
    serve_read(1'b1, 1, 64'h700);

    // All three at once: write, LSU read (len 255), IFU read.
    do_reset();
    p0 = pulses;
    lsu_w_valid_i = 1'b1; lsu_w_addr_i = 32'h8000_2000; lsu_w_size_i = 3'd3; lsu_w_len_i = 8'd3;
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_3000; lsu_r_size_i = 3'd3; lsu_r_len_i = 8'd255;
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0200; ifu_r_size_i = 3'd2; ifu_r_len_i = 8'd0;
    push_exp(1'b1, 32'h8000_2000, 3'd3, 8'd3);
    push_exp(1'b0, 32'h8000_3000, 3'd3, 8'd255);
    push_exp(1'b0, 32'h8000_0200, 3'd2, 8'd0);
    await_grant("all3_wr", n);
    serve_write(4, 64'hA0, 32'h8000_2000);
    await_grant("all3_lsu", n);
    serve_read(1'b1, 2, 64'h800);
    await_grant("all3_ifu", n);
    serve_read(1'b0, 1, 64'h900);
    step();
    step();
    check("all3_pulse_count", 64'(pulses - p0), 64'(3));

    // Reset during beat 2 of an LSU read burst.
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_4000; lsu_r_size_i = 3'd3; lsu_r_len_i = 8'd3;
    push_exp(1'b0, 32'h8000_4000, 3'd3, 8'd3);
    await_grant("rst_burst", n);
    cpu_r_ready_i = 1'b1; cpu_r_last_i = 1'b0; cpu_r_data_i = 64'hB01;
    #1;
    check("rst_burst_beat1", 64'(lsu_r_ready_o), 64'(1));
    step();
    cpu_r_data_i = 64'hB02;
    areset_n = 1'b0;
    #1;
    check_all_zero("rst_midburst_comb");
    step();
    check_all_zero("rst_midburst_held");
    areset_n = 1'b1;
    lsu_r_valid_i = 1'b0;
    cpu_r_ready_i = 1'b0;
    cpu_r_data_i  = '0;
    #1;
    check_all_zero("rst_after_idle");
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0300; ifu_r_size_i = 3'd2; ifu_r_len_i = 8'd0;
    push_exp(1'b0, 32'h8000_0300, 3'd2, 8'd0);
    await_grant("post_rst_ifu", n);
    check("post_rst_latency", 64'(n), 64'(1));
    serve_read(1'b0, 1, 64'hC00);
    step();

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
